// File: rtl/rot_pkg.sv
// Shared definitions for the serial rotator.
//   state_t    : controller states IDLE / SHIFT / HOLD
//   ROT_LEFT   : direction code for rotate-left  (0)
//   ROT_RIGHT  : direction code for rotate-right (1)
//   amt_w(n)   : width of a rotate amount for an n-bit word
package rot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

  // Amount field must index 0..n-1; n is a power of two and at least 2.
  function automatic int amt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rot1_step.sv
// Single-position rotator, purely combinational.
// Ports:
//   d   in  N  word to rotate
//   dir in  1  ROT_LEFT / ROT_RIGHT
//   y   out N  d rotated by one bit in direction dir
module rot1_step
  import rot_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] d,
  input  logic         dir,
  output logic [N-1:0] y
);

  assign y = (dir == ROT_RIGHT) ? {d[0], d[N-1:1]} : {d[N-2:0], d[N-1]};

endmodule

// File: rtl/serial_rot_ctrl.sv
// Serial rotator: accepts a word, rotates it one bit per clock until the
// requested amount is reached, then holds the result until it is taken.
// Ports:
//   clk       in  1   clock, rising edge
//   rst_n     in  1   asynchronous active-low reset
//   in_valid  in  1   request present
//   in_ready  out 1   idle and able to accept
//   in_data   in  N   word to rotate
//   in_amt    in  AW  rotate amount 0..N-1
//   in_dir    in  1   0 = left, 1 = right
//   out_valid out 1   result present (HOLD)
//   out_ready in  1   consumer takes the result
//   out_data  out N   data register (valid only with out_valid)
//   busy      out 1   not idle
module serial_rot_ctrl
  import rot_pkg::*;
#(
  parameter  int N  = 4,
  localparam int AW = amt_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  step_y;

  rot1_step #(.N(N)) u_step (
    .d   (data_q),
    .dir (dir_q),
    .y   (step_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= ROT_LEFT;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = in_amt;
          dir_d   = in_dir;
          // A zero amount has nothing to rotate: present the word next cycle.
          state_d = (in_amt == '0) ? HOLD : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step_y;
        cnt_d  = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_serial_rot_ctrl.sv
module tb_serial_rot_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic          in_dir = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_data;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_rot_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Rotation by k positions, computed by moving each bit to its destination.
  function automatic logic [N-1:0] rotm(input logic [N-1:0] d, input int k, input logic dir);
    logic [N-1:0] r;
    int s;
    s = dir ? (N - (k % N)) % N : (k % N);
    r = '0;
    for (int i = 0; i < N; i++) r[(i + s) % N] = d[i];
    return r;
  endfunction

  // Transaction-level model: accepted word, direction, total steps, steps done.
  logic         m_act  = 1'b0;
  logic [N-1:0] m_word = '0;
  logic         m_dir  = 1'b0;
  int           m_tot  = 0;
  int           m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_word <= '0; m_dir <= 1'b0; m_tot <= 0; m_done <= 0;
    end else if (!m_act) begin
      if (in_valid) begin
        m_act <= 1'b1; m_word <= in_data; m_dir <= in_dir;
        m_tot <= int'(in_amt); m_done <= 0;
      end
    end else if (m_done < m_tot) begin
      m_done <= m_done + 1;
    end else if (out_ready) begin
      m_act <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("mdl_in_ready",  32'(in_ready),  32'(!m_act));
    chk("mdl_busy",      32'(busy),      32'(m_act));
    chk("mdl_out_valid", 32'(out_valid), 32'(m_act && (m_done == m_tot)));
    chk("mdl_out_data",  32'(out_data),  32'(rotm(m_word, m_done, m_dir)));
  end

  // Called at posedge+2 with the block idle; returns at posedge+2.
  task automatic run(input logic [N-1:0] d, input int amt, input logic dir,
                     input logic [N-1:0] exp, input int hold, input bit noise,
                     input string nm);
    int k;
    logic [N-1:0] held;
    chk({nm, "_pre_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_amt = AW'(amt); in_dir = dir; out_ready = 1'b0;
    @(posedge clk);
    #2;
    if (noise) begin
      in_data = ~d; in_amt = AW'(amt + 1); in_dir = ~dir;
    end else begin
      in_valid = 1'b0;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (noise) in_data = N'($urandom);
    end while (!out_valid && k < 20);
    chk({nm, "_latency"}, 32'(k), 32'(amt + 1));
    chk({nm, "_data"}, 32'(out_data), 32'(exp));
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_data"},  32'(out_data),  32'(held));
      chk({nm, "_hold_ready"}, 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_post_ready"}, 32'(in_ready),  32'd1);
    chk({nm, "_post_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    run(4'b0110, 1, 1'b0, 4'b1100, 0, 1'b0, "l1");
    run(4'b0110, 1, 1'b1, 4'b0011, 0, 1'b0, "r1");
    run(4'b0110, 2, 1'b0, 4'b1001, 0, 1'b0, "l2");
    run(4'b0110, 2, 1'b1, 4'b1001, 0, 1'b0, "r2");
    run(4'b0110, 3, 1'b0, 4'b0011, 0, 1'b0, "l3");
    run(4'b0110, 3, 1'b1, 4'b1100, 0, 1'b0, "r3");
    run(4'b0110, 0, 1'b0, 4'b0110, 0, 1'b0, "a0");
    run(4'b1011, 2, 1'b1, 4'b1110, 5, 1'b0, "bp");
    run(4'b0110, 2, 1'b0, 4'b1001, 1, 1'b1, "noise");

    // Abort mid-rotation.
    in_valid = 1'b1; in_data = 4'b0110; in_amt = 2'd3; in_dir = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data",  32'(out_data),  32'd0);
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_busy",      32'(busy),      32'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run(4'b1001, 1, 1'b0, 4'b0011, 0, 1'b0, "after_rst");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
